dummy_accelerator_result_fifo: RTL and testbench
================================================

Name: dummy_accelerator_result_fifo

Overview:
- Result buffer directly downstream of the dummy accelerator.
- Captures each result/tag pair on the accelerator's valid/ready output handshake and holds it until the result/writeback interface accepts it.
- Decouples accelerator completion from writeback stalls, so the accelerator can complete up to DEPTH operations while writeback is blocked.
- Fully registered FIFO. No combinational path from any input to any output.

Parameters:
- WIDTH, 32: result data width in bits.
- TAG_WIDTH, 5: tag width in bits (carries rd/id).
- DEPTH, 4: number of entries. Must be a power of two, >= 2.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- flush_i  input  1  synchronous flush; discards all entries.
- valid_i  input  1  upstream (accelerator) result valid.
- ready_o  output  1  space available; push accepted when valid_i && ready_o.
- result_i  input  WIDTH  upstream result.
- tag_i  input  TAG_WIDTH  upstream tag.
- valid_o  output  1  head entry valid toward writeback.
- ready_i  input  1  writeback ready; pop when valid_o && ready_i.
- result_o  output  WIDTH  head entry result.
- tag_o  output  TAG_WIDTH  head entry tag.
- count_o  output  $clog2(DEPTH+1)  current occupancy.
- full_o  output  1  count_o == DEPTH.
- empty_o  output  1  count_o == 0.

Behaviour:
- State:
  - Storage array of DEPTH entries {result, tag}.
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0.
  - count register, 0..DEPTH.
- Reset (rst_i high, asynchronous): wr_ptr = rd_ptr = count = 0. Resulting outputs: valid_o=0, ready_o=1, full_o=0, empty_o=1, count_o=0, result_o='0, tag_o='0. Storage contents are not reset.
- Derived outputs: ready_o = !full_o; valid_o = !empty_o. All derive from registered count only; ready_o does not depend on ready_i.
- Data outputs: result_o/tag_o = storage[rd_ptr] when !empty_o, otherwise '0. Gating to '0 is mandatory for determinism.
- Push: on push, storage[wr_ptr] <= {result_i, tag_i} and wr_ptr++.
- Pop: on pop, rd_ptr++.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. Both pointers still advance.
- Latency: an entry pushed at edge N is presented on valid_o/result_o after edge N and can be popped at edge N+1 at the earliest. There is no bypass.
- Full: push is impossible because ready_o=0, even if a pop occurs in the same cycle. ready_o rises the cycle after the pop.
- Empty: pop is impossible because valid_o=0. A push into an empty FIFO makes valid_o high the next cycle.
- Ordering: strict FIFO. Tags leave in exactly the order they entered.
- Handshake stability: while valid_o=1 and ready_i=0, result_o/tag_o/valid_o hold stable.
- flush_i (synchronous, evaluated at the edge):
  - Highest priority over push and pop in the same cycle. The push is dropped and the pop does not occur.
  - Next cycle: count=0, wr_ptr=rd_ptr=0, valid_o=0, ready_o=1.
- Reset mid-operation: any buffered entries are lost. Outputs take reset values immediately, without waiting for an edge.
- Upstream protocol: result_i/tag_i are sampled only on a push. Upstream is not required to hold valid_i while ready_o=0, although the accelerator does.
- Simulation assertions (required):
  - No push when count==DEPTH.
  - No pop when count==0.
  - count_o == (wr_ptr - rd_ptr) mod DEPTH, except when full (count=DEPTH, pointers equal).
  - result_o/tag_o stable while valid_o && !ready_i.

Test Plan:
1. Reset then idle → valid_o=0, ready_o=1, empty_o=1, count_o=0, result_o=0, tag_o=0.
2. Single push result_i=0x0000_00A5, tag_i=3 with ready_i=0 → next cycle valid_o=1, result_o=0xA5, tag_o=3, count_o=1. Then raise ready_i → popped; next cycle empty_o=1.
3. Fill with ready_i=0, pushing results 0x10..0x13 with tags 0..3 (DEPTH=4) → after 4th push full_o=1, ready_o=0, count_o=4; a 5th valid_i is not accepted. Drain with ready_i=1 → outputs 0x10,0x11,0x12,0x13 with tags 0,1,2,3 on consecutive cycles.
4. Continuous push and pop at count=2 for 10 cycles (exercising pointer wrap) → count_o stays 2, output order matches input order, and no value is lost or duplicated across the pointer wrap.
5. With count=3, assert flush_i in the same cycle as valid_i=1 and ready_i=1 → next cycle count_o=0, valid_o=0, ready_o=1; the flushed push never appears on the output.
6. Assert rst_i asynchronously mid-cycle at count=2 → valid_o drops to 0 and count_o to 0 before the next clock edge. After release, a push of 0xDEAD_BEEF with tag 7 emerges correctly.

Source files
------------

// File: rtl/dummy_accelerator_result_fifo.sv
// Result buffer between the dummy accelerator and writeback: a fully registered
// FIFO of {result, tag} entries with flush, occupancy and full/empty flags.
module dummy_accelerator_result_fifo #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 5,
    parameter int DEPTH     = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [WIDTH-1:0]             result_i,
    input  logic [TAG_WIDTH-1:0]         tag_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [WIDTH-1:0]             result_o,
    output logic [TAG_WIDTH-1:0]         tag_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = WIDTH + TAG_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] storage [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               write_en;
    logic               read_en;
    logic [ENTRY_W-1:0] head;

    // Every handshake output is a function of the registered count only.
    assign full_o   = (count_reg == DEPTH_C);
    assign empty_o  = (count_reg == '0);
    assign ready_o  = !full_o;
    assign valid_o  = !empty_o;
    assign count_o  = count_reg;

    // Flush wins over both handshakes taking place in the same cycle.
    assign write_en = valid_i && ready_o && !flush_i;
    assign read_en  = valid_o && ready_i && !flush_i;

    assign head     = storage[rd_ptr_reg];
    assign result_o = empty_o ? '0 : head[ENTRY_W-1:TAG_WIDTH];
    assign tag_o    = empty_o ? '0 : head[TAG_WIDTH-1:0];

    // Storage is intentionally left out of reset; stale entries are masked by empty_o.
    always_ff @(posedge clk_i) begin
        if (write_en) begin
            storage[wr_ptr_reg] <= {result_i, tag_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (write_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (read_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({write_en, read_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifndef SYNTHESIS
    ap_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(valid_i && ready_o && count_reg == DEPTH_C));

    ap_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(valid_o && ready_i && count_reg == '0));

    ap_count_ptrs: assert property (@(posedge clk_i) disable iff (rst_i)
        (count_reg == DEPTH_C) ? (wr_ptr_reg == rd_ptr_reg)
                               : (count_reg == CNT_W'(PTR_W'(wr_ptr_reg - rd_ptr_reg))));

    // A stalled head must not change until writeback takes it.
    ap_head_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        $past(valid_o && !ready_i && !flush_i && !rst_i) |->
            (valid_o && result_o == $past(result_o) && tag_o == $past(tag_o)));
`endif

endmodule

// File: tb/tb_dummy_accelerator_result_fifo.sv
// Directed bench for dummy_accelerator_result_fifo: stimulus queues expected entries,
// a negedge monitor pops and compares each entry writeback accepts.
module tb_dummy_accelerator_result_fifo;

    localparam int WIDTH     = 32;
    localparam int TAG_WIDTH = 5;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = $clog2(DEPTH+1);

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 flush_i = 1'b0;
    logic                 valid_i = 1'b0;
    logic                 ready_o;
    logic [WIDTH-1:0]     result_i = '0;
    logic [TAG_WIDTH-1:0] tag_i = '0;
    logic                 valid_o;
    logic                 ready_i = 1'b0;
    logic [WIDTH-1:0]     result_o;
    logic [TAG_WIDTH-1:0] tag_o;
    logic [CNT_W-1:0]     count_o;
    logic                 full_o;
    logic                 empty_o;

    logic [WIDTH+TAG_WIDTH-1:0] sb [$];
    int checks = 0;
    int errors = 0;
    int pops   = 0;

    dummy_accelerator_result_fifo #(
        .WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .result_i(result_i), .tag_i(tag_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .tag_o(tag_o),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drives one upstream beat; the entry is queued only when the bench knows it fits.
    task automatic offer(input logic [WIDTH-1:0] r, input logic [TAG_WIDTH-1:0] t,
                         input bit accepted);
        valid_i  = 1'b1;
        result_i = r;
        tag_i    = t;
        if (accepted) sb.push_back({r, t});
        $display("push result=%08h tag=%0d accepted=%0d", r, t, accepted);
    endtask

    task automatic check_idle(input string name);
        check({name, ".valid_o"}, 64'(valid_o), 64'd0);
        check({name, ".ready_o"}, 64'(ready_o), 64'd1);
        check({name, ".empty_o"}, 64'(empty_o), 64'd1);
        check({name, ".count_o"}, 64'(count_o), 64'd0);
    endtask

    // Monitor: a pop happens at the coming posedge whenever this holds at the negedge.
    initial begin
        logic [WIDTH+TAG_WIDTH-1:0] exp;
        forever begin
            @(negedge clk_i);
            if (!rst_i && !flush_i && valid_o && ready_i) begin
                pops++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got result=%08h tag=%0d expected no entry",
                             result_o, tag_o);
                end else begin
                    exp = sb.pop_front();
                    $display("pop  result=%08h tag=%0d", result_o, tag_o);
                    check("pop.result", 64'(result_o), 64'(exp[WIDTH+TAG_WIDTH-1:TAG_WIDTH]));
                    check("pop.tag", 64'(tag_o), 64'(exp[TAG_WIDTH-1:0]));
                end
            end
        end
    end

    initial begin
        // 1: reset then idle
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        check_idle("reset");
        check("reset.full_o", 64'(full_o), 64'd0);
        check("reset.result_o", 64'(result_o), 64'd0);
        check("reset.tag_o", 64'(tag_o), 64'd0);

        // 2: single entry, held by writeback, then popped
        offer(32'h0000_00A5, 5'd3, 1'b1);
        tick();
        valid_i = 1'b0;
        check("single.valid_o", 64'(valid_o), 64'd1);
        check("single.result_o", 64'(result_o), 64'h0000_00A5);
        check("single.tag_o", 64'(tag_o), 64'd3);
        check("single.count_o", 64'(count_o), 64'd1);
        tick();
        check("single.hold_result", 64'(result_o), 64'h0000_00A5);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check_idle("single_drained");

        // 3: fill to full, reject the extra beat, drain back to back
        for (int i = 0; i < DEPTH; i++) begin
            offer(32'h10 + 32'(i), 5'(i), 1'b1);
            tick();
        end
        check("fill.full_o", 64'(full_o), 64'd1);
        check("fill.ready_o", 64'(ready_o), 64'd0);
        check("fill.count_o", 64'(count_o), 64'd4);
        offer(32'h99, 5'd9, 1'b0);
        tick();
        valid_i = 1'b0;
        check("fill.reject_count", 64'(count_o), 64'd4);
        ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain.valid_o", 64'(valid_o), 64'd1);
            check("drain.count_o", 64'(count_o), 64'(DEPTH - i));
            tick();
        end
        ready_i = 1'b0;
        check_idle("drained");

        // 4: steady push+pop at count 2 across pointer wrap
        offer(32'h20, 5'd10, 1'b1);
        tick();
        offer(32'h21, 5'd11, 1'b1);
        tick();
        ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            offer(32'h30 + 32'(k), 5'(12 + k), 1'b1);
            tick();
            check("stream.count_o", 64'(count_o), 64'd2);
        end
        valid_i = 1'b0;
        tick();
        tick();
        ready_i = 1'b0;
        check_idle("stream_drained");

        // 5: flush with simultaneous push and pop at count 3
        for (int i = 0; i < 3; i++) begin
            offer(32'h40 + 32'(i), 5'(1 + i), 1'b1);
            tick();
        end
        valid_i = 1'b0;
        check("preflush.count_o", 64'(count_o), 64'd3);
        flush_i = 1'b1;
        ready_i = 1'b1;
        sb.delete();
        offer(32'h55, 5'h1F, 1'b0);
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        check_idle("flush");
        offer(32'h60, 5'd4, 1'b1);
        tick();
        valid_i = 1'b0;
        check("postflush.result_o", 64'(result_o), 64'h60);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check_idle("postflush_drained");

        // 6: asynchronous reset mid-cycle at count 2
        offer(32'h70, 5'd5, 1'b1);
        tick();
        offer(32'h71, 5'd6, 1'b1);
        tick();
        valid_i = 1'b0;
        check("prereset.count_o", 64'(count_o), 64'd2);
        #2;
        rst_i = 1'b1;
        sb.delete();
        #1;
        check_idle("async_reset");
        check("async_reset.result_o", 64'(result_o), 64'd0);
        tick();
        rst_i = 1'b0;
        offer(32'hDEAD_BEEF, 5'd7, 1'b1);
        tick();
        valid_i = 1'b0;
        check("postreset.valid_o", 64'(valid_o), 64'd1);
        check("postreset.result_o", 64'(result_o), 64'hDEAD_BEEF);
        check("postreset.tag_o", 64'(tag_o), 64'd7);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check_idle("postreset_drained");

        tick();
        check("scoreboard.leftover", 64'(sb.size()), 64'd0);
        check("scoreboard.pops", 64'(pops), 64'd19);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
